// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
//
// Upstream stage of the systolic core. Activation rows are buffered in a small
// FIFO. One weight vector is accepted per job, and then the core's
// load/weights/activations inputs are driven. Lane i of every popped row is
// delayed by i extra cycles, so wavefronts enter the array diagonally. After
// the row marked last, zeros flush the array for 2*ARRAY_SIZE cycles, so the
// core's outputs can complete.
//
// Job sequence: IDLE -> LOAD -> STREAM -> DRAIN -> IDLE
//
// Parameters
//   ARRAY_SIZE  lanes (rows/cols of the core), >= 2
//   DATA_WIDTH  bits per activation/weight element
//   FIFO_DEPTH  activation-row FIFO entries, power of 2, >= 2
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high; abandons any job in flight
//   in_valid     activation row offered
//   in_ready     FIFO can accept (not full); 0 while reset
//   in_data      row; lane i = in_data[i*DATA_WIDTH +: DATA_WIDTH]
//   in_last      marks the final row of a job (stored with the row)
//   w_valid      weight vector offered
//   w_ready      high only in IDLE
//   w_data       weight vector
//   load         1-cycle pulse to the core (LOAD state only)
//   weights      registered weight vector; held until the next IDLE handshake
//   activations  skewed activations to the core
//   busy         job in progress (state != IDLE)
//   done         1-cycle pulse on the final DRAIN cycle
//   row_count    (FEEDER_STATS_EN only) number of rows streamed in the current
//                or most recent job; saturates at 16'hFFFF
//
// Build option
//   `define FEEDER_STATS_EN  adds the row_count output and its counter.
// -----------------------------------------------------------------------------
module systolic_feeder #(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_data,
  input  logic                             in_last,
  input  logic                             w_valid,
  output logic                             w_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] w_data,
  output logic                             load,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] weights,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] activations,
  output logic                             busy,
  output logic                             done
`ifdef FEEDER_STATS_EN
  ,
  output logic [15:0]                      row_count
`endif
);

  localparam int ROW_W   = ARRAY_SIZE * DATA_WIDTH;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int DRAIN_W = $clog2(2 * ARRAY_SIZE + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // ---------------------------------------------------------------------------
  // Activation FIFO. Each entry stores {last, row}.
  // The head entry is read combinationally. A row popped in cycle t must reach
  // lane 0 in cycle t+1, so a registered read would cost a cycle that the skew
  // timing does not allow.
  // ---------------------------------------------------------------------------
  logic [ROW_W:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [ROW_W:0]     head_entry;
  logic [ROW_W-1:0]   head_row;
  logic               head_last;

  assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);

  // Ready depends only on the registered count. When the FIFO is full, a pop
  // in this cycle does not make room until the next cycle.
  assign in_ready   = !reset && !fifo_full;
  assign push       = in_valid && in_ready;

  assign head_entry = fifo_mem[rd_ptr_reg];
  assign head_row   = head_entry[ROW_W-1:0];
  assign head_last  = head_entry[ROW_W];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {in_last, in_data};
    end
  end

  // The pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Drain counter: loaded when the last row is popped, then counts down to 1.
  // ---------------------------------------------------------------------------
  logic [DRAIN_W-1:0] drain_cnt_reg;
  logic               drain_final;

  assign drain_final = (drain_cnt_reg == DRAIN_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      drain_cnt_reg <= '0;
    end else if (pop && head_last) begin
      drain_cnt_reg <= DRAIN_W'(2 * ARRAY_SIZE);
    end else if (state_reg == S_DRAIN) begin
      drain_cnt_reg <= drain_cnt_reg - DRAIN_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (w_valid)            state_next = S_LOAD;
      S_LOAD:                           state_next = S_STREAM;
      S_STREAM: if (pop && head_last)   state_next = S_DRAIN;
      S_DRAIN:  if (drain_final)        state_next = S_IDLE;
      default:                          state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Everything here is forced low while reset is high, so a
  // job abandoned by reset never produces a stray load or done pulse.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ready = 1'b0;
    load    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    pop     = 1'b0;
    if (!reset) begin
      w_ready = (state_reg == S_IDLE);
      load    = (state_reg == S_LOAD);
      busy    = (state_reg != S_IDLE);
      done    = (state_reg == S_DRAIN) && drain_final;
      pop     = (state_reg == S_STREAM) && !fifo_empty;
    end
  end

  // ---------------------------------------------------------------------------
  // Weight register: captured on the IDLE handshake and held for the whole job.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      weights <= '0;
    end else if (w_valid && w_ready) begin
      weights <= w_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Skew network: lane gi has gi+1 register stages.
  // When nothing is popped, the first stage loads zero. Bubbles and the drain
  // therefore flush the array with zeros.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
    logic [DATA_WIDTH-1:0] stage_reg [gi+1];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k <= gi; k++) begin
          stage_reg[k] <= '0;
        end
      end else begin
        stage_reg[0] <= pop ? head_row[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int k = 1; k <= gi; k++) begin
          stage_reg[k] <= stage_reg[k-1];
        end
      end
    end

    assign activations[gi*DATA_WIDTH +: DATA_WIDTH] = stage_reg[gi];
  end

`ifdef FEEDER_STATS_EN
  // ---------------------------------------------------------------------------
  // Row statistics: cleared when a job starts, so after done the counter
  // reports the size of the job that just finished.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      row_count <= '0;
    end else if (state_reg == S_LOAD) begin
      row_count <= '0;
    end else if (pop && (row_count != 16'hFFFF)) begin
      row_count <= row_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_feeder
//
// Directed bench for systolic_feeder with ARRAY_SIZE=4, DATA_WIDTH=4 and
// FIFO_DEPTH=4.
//
// Timing: inputs are driven 1 ns after a rising edge. Outputs are sampled at
// the same point, so the values seen reflect the state after that edge.
//
// Define FEEDER_STATS_EN to also exercise the row_count output.
// -----------------------------------------------------------------------------
module tb_systolic_feeder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        w_valid;
  logic        w_ready;
  logic [15:0] w_data;
  logic        load;
  logic [15:0] weights;
  logic [15:0] activations;
  logic        busy;
  logic        done;
`ifdef FEEDER_STATS_EN
  logic [15:0] row_count;
`endif

  int checks;
  int failures;

  systolic_feeder #(
    .ARRAY_SIZE(4),
    .DATA_WIDTH(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_data      (w_data),
    .load        (load),
    .weights     (weights),
    .activations (activations),
    .busy        (busy),
    .done        (done)
`ifdef FEEDER_STATS_EN
    ,
    .row_count   (row_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reset state, then a reset asserted mid-STREAM with 3 rows still queued.
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [15:0] rows [4];
    rows[0] = 16'h1357; rows[1] = 16'h2468; rows[2] = 16'h9BDF; rows[3] = 16'hACE0;

    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({in_ready, w_ready, busy, load, done} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got rdy/wrdy/busy/load/done=%b want 00000",
               {in_ready, w_ready, busy, load, done});
    end
    checks++;
    if (weights !== 16'h0 || activations !== 16'h0) begin
      failures++;
      $display("FAIL reset_data: got weights=%h act=%h want 0000/0000", weights, activations);
    end

    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || w_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got rdy=%b wrdy=%b busy=%b want 1 1 0", in_ready, w_ready, busy);
    end

    // Fill the FIFO, then start a job.
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = rows[k]; in_last = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_in_ready: got %b want 0", in_ready);
    end
    w_valid = 1'b1; w_data = 16'h5A5A;
    tick();                       // LOAD
    w_valid = 1'b0;
    tick();                       // STREAM, the first pop happens now
    tick();                       // STREAM, 3 rows queued
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_stream_busy: got %b want 1", busy);
    end

    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL during_reset: got rdy=%b busy=%b done=%b want 0 0 0", in_ready, busy, done);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy, load, done} !== 4'b1000 || weights !== 16'h0 || activations !== 16'h0) begin
      failures++;
      $display("FAIL after_mid_reset: got rdy/busy/load/done=%b w=%h act=%h want 1000 0000 0000",
               {in_ready, busy, load, done}, weights, activations);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || activations !== 16'h0) begin
        failures++;
        $display("FAIL abandoned_job c%0d: got done=%b busy=%b act=%h want 0 0 0000",
                 k, done, busy, activations);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Weight handshake: load pulses exactly one cycle later. Leaves the DUT in
  // STREAM with an empty FIFO, which test_bubble continues from.
  // ---------------------------------------------------------------------------
  task automatic test_load();
    w_valid = 1'b1; w_data = 16'h4321;
    #1;
    checks++;
    if (w_ready !== 1'b1 || load !== 1'b0) begin
      failures++;
      $display("FAIL idle_handshake: got wrdy=%b load=%b want 1 0", w_ready, load);
    end
    tick();
    w_valid = 1'b0; w_data = 16'hFFFF;
    checks++;
    if (load !== 1'b1 || weights !== 16'h4321 || busy !== 1'b1 || w_ready !== 1'b0) begin
      failures++;
      $display("FAIL load_cycle: got load=%b w=%h busy=%b wrdy=%b want 1 4321 1 0",
               load, weights, busy, w_ready);
    end
    tick();
    checks++;
    if (load !== 1'b0 || weights !== 16'h4321 || busy !== 1'b1) begin
      failures++;
      $display("FAIL after_load: got load=%b w=%h busy=%b want 0 4321 1", load, weights, busy);
    end
  endtask

  // ---------------------------------------------------------------------------
  // STREAM with an empty FIFO injects zeros and stays put. Then a last row of
  // 16'h1111 skews through the lanes and the drain finishes.
  // ---------------------------------------------------------------------------
  task automatic test_bubble();
    logic [15:0] exp_act;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || activations !== 16'h0 || done !== 1'b0 || load !== 1'b0) begin
        failures++;
        $display("FAIL bubble c%0d: got busy=%b act=%h done=%b load=%b want 1 0000 0 0",
                 k, busy, activations, done, load);
      end
    end
    in_valid = 1'b1; in_data = 16'h1111; in_last = 1'b1;
    tick();                       // row is in the FIFO and is popped now (cycle t)
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (activations !== 16'h0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL bubble_pop: got act=%h busy=%b want 0000 1", activations, busy);
    end
    for (int d = 1; d <= 8; d++) begin
      tick();
      exp_act = (d <= 4) ? (16'h0001 << (4 * (d - 1))) : 16'h0;
      checks++;
      if (activations !== exp_act || done !== (d == 8) || busy !== 1'b1) begin
        failures++;
        $display("FAIL bubble_skew t+%0d: got act=%h done=%b busy=%b want %h %b 1",
                 d, activations, done, busy, exp_act, (d == 8));
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL bubble_end: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  // ---------------------------------------------------------------------------
  // A single row 16'hDCBA marked last: A, B, C, D appear on lanes 0..3 at
  // t+1..t+4, and done pulses at t+8.
  // ---------------------------------------------------------------------------
  task automatic test_skew();
    logic [15:0] row;
    logic [15:0] exp_act;
    row = 16'hDCBA;
    in_valid = 1'b1; in_data = row; in_last = 1'b1;
    w_valid = 1'b1; w_data = 16'h0F0F;
    tick();                       // LOAD
    in_valid = 1'b0; in_last = 1'b0; w_valid = 1'b0;
    checks++;
    if (load !== 1'b1) begin
      failures++;
      $display("FAIL skew_load: got %b want 1", load);
    end
    tick();                       // STREAM, pop at cycle t
    checks++;
    if (activations !== 16'h0 || load !== 1'b0) begin
      failures++;
      $display("FAIL skew_t: got act=%h load=%b want 0000 0", activations, load);
    end
    for (int d = 1; d <= 8; d++) begin
      tick();
      exp_act = (d <= 4) ? (row & (16'h000F << (4 * (d - 1)))) : 16'h0;
      checks++;
      if (activations !== exp_act || done !== (d == 8) || load !== 1'b0) begin
        failures++;
        $display("FAIL skew t+%0d: got act=%h done=%b load=%b want %h %b 0",
                 d, activations, done, load, exp_act, (d == 8));
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || weights !== 16'h0F0F) begin
      failures++;
      $display("FAIL skew_end: got busy=%b w=%h want 0 0f0f", busy, weights);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Five rows are offered back to back in IDLE. in_ready drops after the 4th,
  // and the 5th is held until a STREAM pop frees a slot. All five rows stream
  // diagonally.
  // Cycle map: c0-c3 push rows 0-3, c4 weights handshake, c5 LOAD, pops at
  // c6-c10 (row 4 is pushed at c7), done at c18.
  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [15:0] rows [5];
    logic [15:0] exp_act;
    int          p;
    rows[0] = 16'h1234; rows[1] = 16'h5678; rows[2] = 16'h9ABC;
    rows[3] = 16'hDEF0; rows[4] = 16'h2468;
    for (int c = 0; c <= 19; c++) begin
      in_valid = (c <= 7);
      in_data  = rows[(c < 4) ? c : 4];
      in_last  = (c >= 4);
      w_valid  = (c == 4);
      w_data   = 16'hA5A5;
      #1;
      exp_act = 16'h0;
      for (int i = 0; i < 4; i++) begin
        p = c - 1 - i;
        if (p >= 6 && p <= 10) begin
          exp_act[i*4 +: 4] = rows[p-6][i*4 +: 4];
        end
      end
      checks++;
      if (in_ready !== !(c >= 4 && c <= 6)) begin
        failures++;
        $display("FAIL b2b_in_ready c%0d: got %b want %b", c, in_ready, !(c >= 4 && c <= 6));
      end
      checks++;
      if (activations !== exp_act) begin
        failures++;
        $display("FAIL b2b_act c%0d: got %h want %h", c, activations, exp_act);
      end
      checks++;
      if (done !== (c == 18) || busy !== (c >= 5 && c <= 18) || load !== (c == 5)) begin
        failures++;
        $display("FAIL b2b_ctrl c%0d: got done=%b busy=%b load=%b want %b %b %b",
                 c, done, busy, load, (c == 18), (c >= 5 && c <= 18), (c == 5));
      end
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0; w_valid = 1'b0;
  endtask

`ifdef FEEDER_STATS_EN
  // ---------------------------------------------------------------------------
  // row_count: 3 after a 3-row job, held in IDLE and LOAD, then 0 after the
  // next LOAD.
  // ---------------------------------------------------------------------------
  task automatic test_stats();
    logic seen;
    in_valid = 1'b1; in_data = 16'h0102; in_last = 1'b0;
    w_valid = 1'b1; w_data = 16'h7777;
    tick();                       // LOAD
    w_valid = 1'b0;
    in_data = 16'h0304;
    tick();                       // STREAM
    checks++;
    if (row_count !== 16'd0) begin
      failures++;
      $display("FAIL stats_cleared: got %0d want 0", row_count);
    end
    in_data = 16'h0506; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      tick();
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL stats_done_timeout: got no done want done within 30 cycles");
    end
    tick();
    checks++;
    if (row_count !== 16'd3 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stats_after_done: got count=%0d busy=%b want 3 0", row_count, busy);
    end
    w_valid = 1'b1; w_data = 16'h1234;
    tick();                       // LOAD
    w_valid = 1'b0;
    checks++;
    if (row_count !== 16'd3) begin
      failures++;
      $display("FAIL stats_hold_load: got %0d want 3", row_count);
    end
    tick();                       // STREAM
    checks++;
    if (row_count !== 16'd0) begin
      failures++;
      $display("FAIL stats_after_load: got %0d want 0", row_count);
    end
    in_valid = 1'b1; in_data = 16'h4444; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      tick();
      if (done) seen = 1'b1;
    end
    tick();
    checks++;
    if (!seen || row_count !== 16'd1) begin
      failures++;
      $display("FAIL stats_second_job: got done_seen=%b count=%0d want 1 1", seen, row_count);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 16'h0;
    in_last  = 1'b0;
    w_valid  = 1'b0;
    w_data   = 16'h0;

    test_reset();
    test_load();
    test_bubble();          // continues in STREAM from test_load
    test_skew();
    test_back_to_back();
`ifdef FEEDER_STATS_EN
    test_stats();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
